// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - pipelined control decoder with load-use, flush, stall and halt handling
//
// Purpose:
//   Decodes the ID-stage opcode (WISC 5-bit map) into a control bundle and
//   carries it through ID/EX, EX/MEM and MEM/WB registers. Detects load-use
//   hazards and inserts one bubble, squashes ID on flush, freezes the whole pipe
//   on an external stall, and latches a sticky halt once a halt reaches WB.
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//   defined   - illegal opcode sets a sticky error and enters the pipe as a halt
//   undefined - error is a one-cycle combinational pulse; the instruction enters
//               as a valid NOP with every control bit cleared
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   i_id_valid, i_id_opcode    ID instruction present / opcode
//   i_id_rs, i_id_rt           ID source registers
//   i_id_rs_used, i_id_rt_used which sources the ID instruction reads
//   i_id_wr_reg                ID destination register
//   i_flush                    squash ID (branch/jump resolved in EX)
//   i_stall_ext                freeze every stage
//   o_hazard_stall             hold PC and IF/ID this cycle
//   o_ex_*                     EX-stage controls (1 cycle after ID)
//   o_mem_*                    MEM-stage controls (2 cycles after ID)
//   o_wb_*                     WB-stage controls (3 cycles after ID)
//   o_halted                   sticky: a halt reached WB
//   o_err                      illegal opcode indication

module ctrl_pipe #(
    parameter int OPC_W = 5,
    parameter int REG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_id_valid,
    input  logic [OPC_W-1:0] i_id_opcode,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_rs_used,
    input  logic             i_id_rt_used,
    input  logic [REG_W-1:0] i_id_wr_reg,
    input  logic             i_flush,
    input  logic             i_stall_ext,
    output logic             o_hazard_stall,
    output logic             o_ex_valid,
    output logic [OPC_W-1:0] o_ex_aluop,
    output logic             o_ex_alusrc,
    output logic             o_ex_branch,
    output logic             o_ex_jump,
    output logic             o_ex_i1fmt,
    output logic             o_ex_zeroext,
    output logic             o_mem_valid,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_wb_valid,
    output logic             o_wb_regwrite,
    output logic             o_wb_memtoreg,
    output logic [REG_W-1:0] o_wb_wr_reg,
    output logic             o_halted,
    output logic             o_err
);

    typedef struct packed {
        logic             valid;
        logic             halt;
        logic [OPC_W-1:0] aluop;
        logic             alusrc;
        logic             branch;
        logic             jump;
        logic             i1fmt;
        logic             zeroext;
        logic             memread;
        logic             memwrite;
        logic             regwrite;
        logic             memtoreg;
        logic [REG_W-1:0] wr_reg;
    } ctrl_t;

    logic [4:0]       w_op;
    logic             w_illegal;
    ctrl_t            w_dec;
    logic             w_hazard;
    logic             w_halted;
    logic             w_id_bubble;

    ctrl_t            r_ex;
    logic             r_mem_valid;
    logic             r_mem_halt;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_mem_regwrite;
    logic             r_mem_memtoreg;
    logic [REG_W-1:0] r_mem_wr_reg;
    logic             r_wb_valid;
    logic             r_wb_halt;
    logic             r_wb_regwrite;
    logic             r_wb_memtoreg;
    logic [REG_W-1:0] r_wb_wr_reg;
    logic             r_halted;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic             r_err;
`endif

    assign w_op = i_id_opcode[4:0];

    // Only opcode bits above the 5-bit map can make an opcode illegal.
    generate
        if (OPC_W > 5) begin : g_wide_opc
            assign w_illegal = |i_id_opcode[OPC_W-1:5];
        end else begin : g_narrow_opc
            assign w_illegal = 1'b0;
        end
    endgenerate

    always_comb begin
        w_dec        = '0;
        w_dec.valid  = 1'b1;
        w_dec.aluop  = i_id_opcode;
        w_dec.wr_reg = i_id_wr_reg;
        casez (w_op)
            5'b00000: w_dec.halt = 1'b1;                       // halt
            5'b00001, 5'b00010, 5'b00011: ;                    // nop, siic, rti
            5'b00100: w_dec.jump = 1'b1;                       // j
            5'b00101: begin                                    // jr
                w_dec.jump   = 1'b1;
                w_dec.alusrc = 1'b1;
            end
            5'b00110: begin                                    // jal
                w_dec.jump     = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            5'b00111: begin                                    // jalr
                w_dec.jump     = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            5'b010??: begin                                    // addi/subi/xori/andni
                w_dec.alusrc   = 1'b1;
                w_dec.i1fmt    = 1'b1;
                w_dec.regwrite = 1'b1;
                w_dec.zeroext  = w_op[1];                      // xori, andni
            end
            5'b011??: w_dec.branch = 1'b1;                     // beqz/bnez/bltz/bgez
            5'b10000: begin                                    // st
                w_dec.alusrc   = 1'b1;
                w_dec.i1fmt    = 1'b1;
                w_dec.memwrite = 1'b1;
            end
            5'b10001: begin                                    // ld
                w_dec.alusrc   = 1'b1;
                w_dec.i1fmt    = 1'b1;
                w_dec.memread  = 1'b1;
                w_dec.regwrite = 1'b1;
                w_dec.memtoreg = 1'b1;
            end
            5'b10010: begin                                    // slbi
                w_dec.alusrc   = 1'b1;
                w_dec.zeroext  = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            5'b10011: begin                                    // stu (writes rs back)
                w_dec.alusrc   = 1'b1;
                w_dec.i1fmt    = 1'b1;
                w_dec.memwrite = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            5'b101??: begin                                    // roli/slli/rori/srli
                w_dec.alusrc   = 1'b1;
                w_dec.i1fmt    = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            5'b11000: begin                                    // lbi
                w_dec.alusrc   = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            default: w_dec.regwrite = 1'b1;                    // R-format 11001..11111
        endcase

        if (w_illegal) begin
            w_dec       = '0;
            w_dec.valid = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
            w_dec.halt  = 1'b1;
`endif
        end
    end

    // A load in EX whose destination the ID instruction reads.
    assign w_hazard = r_ex.valid & r_ex.memread & r_ex.regwrite & i_id_valid &
                      ((i_id_rs_used & (i_id_rs == r_ex.wr_reg)) |
                       (i_id_rt_used & (i_id_rt == r_ex.wr_reg)));

    // Halt is visible in the same cycle it sits valid in WB.
    assign w_halted    = r_halted | (r_wb_valid & r_wb_halt);
    assign w_id_bubble = ~i_id_valid | i_flush | w_hazard | w_halted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex           <= '0;
            r_mem_valid    <= 1'b0;
            r_mem_halt     <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_wr_reg   <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_halt      <= 1'b0;
            r_wb_regwrite  <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_wr_reg    <= '0;
            r_halted       <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            r_err          <= 1'b0;
`endif
        end else begin
            r_halted <= w_halted;
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (i_id_valid & w_illegal) begin
                r_err <= 1'b1;
            end
`endif
            if (!i_stall_ext) begin
                r_ex           <= w_id_bubble ? '0 : w_dec;
                r_mem_valid    <= r_ex.valid;
                r_mem_halt     <= r_ex.halt;
                r_mem_read     <= r_ex.memread;
                r_mem_write    <= r_ex.memwrite;
                r_mem_regwrite <= r_ex.regwrite;
                r_mem_memtoreg <= r_ex.memtoreg;
                r_mem_wr_reg   <= r_ex.wr_reg;
                r_wb_valid     <= r_mem_valid;
                r_wb_halt      <= r_mem_halt;
                r_wb_regwrite  <= r_mem_regwrite;
                r_wb_memtoreg  <= r_mem_memtoreg;
                r_wb_wr_reg    <= r_mem_wr_reg;
            end
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign o_hazard_stall = ~rst & (i_stall_ext | (w_hazard & ~i_flush));

    assign o_ex_valid    = r_ex.valid;
    assign o_ex_aluop    = r_ex.aluop;
    assign o_ex_alusrc   = r_ex.alusrc;
    assign o_ex_branch   = r_ex.branch;
    assign o_ex_jump     = r_ex.jump;
    assign o_ex_i1fmt    = r_ex.i1fmt;
    assign o_ex_zeroext  = r_ex.zeroext;
    assign o_mem_valid   = r_mem_valid;
    assign o_mem_read    = r_mem_read;
    assign o_mem_write   = r_mem_write;
    assign o_wb_valid    = r_wb_valid;
    assign o_wb_regwrite = r_wb_regwrite;
    assign o_wb_memtoreg = r_wb_memtoreg;
    assign o_wb_wr_reg   = r_wb_wr_reg;
    assign o_halted      = w_halted;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign o_err = r_err | (~rst & i_id_valid & w_illegal);
`else
    assign o_err = ~rst & i_id_valid & w_illegal;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - directed scoreboard bench for ctrl_pipe
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_id_valid;
    logic [5:0] i_id_opcode;
    logic [2:0] i_id_rs;
    logic [2:0] i_id_rt;
    logic       i_id_rs_used;
    logic       i_id_rt_used;
    logic [2:0] i_id_wr_reg;
    logic       i_flush;
    logic       i_stall_ext;
    logic       o_hazard_stall;
    logic       o_ex_valid;
    logic [5:0] o_ex_aluop;
    logic       o_ex_alusrc;
    logic       o_ex_branch;
    logic       o_ex_jump;
    logic       o_ex_i1fmt;
    logic       o_ex_zeroext;
    logic       o_mem_valid;
    logic       o_mem_read;
    logic       o_mem_write;
    logic       o_wb_valid;
    logic       o_wb_regwrite;
    logic       o_wb_memtoreg;
    logic [2:0] o_wb_wr_reg;
    logic       o_halted;
    logic       o_err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [5:0] OP_HALT = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_XORI = 6'd10;
    localparam logic [5:0] OP_ST   = 6'd16;
    localparam logic [5:0] OP_LD   = 6'd17;
    localparam logic [5:0] OP_ADD  = 6'd27;
    localparam logic [5:0] OP_BAD  = 6'b100001;

    // Scoreboard entry: {regwrite, memtoreg, wr_reg[2:0]}
    typedef logic [4:0] sb_t;
    sb_t  sb_q[$];
    sb_t  sb_e;
    logic mon_held;

    ctrl_pipe #(.OPC_W(6), .REG_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_id_valid     (i_id_valid),
        .i_id_opcode    (i_id_opcode),
        .i_id_rs        (i_id_rs),
        .i_id_rt        (i_id_rt),
        .i_id_rs_used   (i_id_rs_used),
        .i_id_rt_used   (i_id_rt_used),
        .i_id_wr_reg    (i_id_wr_reg),
        .i_flush        (i_flush),
        .i_stall_ext    (i_stall_ext),
        .o_hazard_stall (o_hazard_stall),
        .o_ex_valid     (o_ex_valid),
        .o_ex_aluop     (o_ex_aluop),
        .o_ex_alusrc    (o_ex_alusrc),
        .o_ex_branch    (o_ex_branch),
        .o_ex_jump      (o_ex_jump),
        .o_ex_i1fmt     (o_ex_i1fmt),
        .o_ex_zeroext   (o_ex_zeroext),
        .o_mem_valid    (o_mem_valid),
        .o_mem_read     (o_mem_read),
        .o_mem_write    (o_mem_write),
        .o_wb_valid     (o_wb_valid),
        .o_wb_regwrite  (o_wb_regwrite),
        .o_wb_memtoreg  (o_wb_memtoreg),
        .o_wb_wr_reg    (o_wb_wr_reg),
        .o_halted       (o_halted),
        .o_err          (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [5:0] op, input logic [2:0] rs, input logic rsu,
                       input logic [2:0] rt, input logic rtu, input logic [2:0] wr);
        i_id_valid   = v;
        i_id_opcode  = op;
        i_id_rs      = rs;
        i_id_rs_used = rsu;
        i_id_rt      = rt;
        i_id_rt_used = rtu;
        i_id_wr_reg  = wr;
    endtask

    task automatic idle();
        drv(1'b0, 6'd0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    task automatic push(input logic rw, input logic mtr, input logic [2:0] wr);
        sb_q.push_back({rw, mtr, wr});
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // WB monitor: every new valid WB entry must match the oldest expectation.
    always begin
        @(posedge clk);
        mon_held = i_stall_ext | rst;
        #3;
        if (!mon_held && !rst && o_wb_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_wb", 32'd1, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_wb_regwrite", {31'd0, o_wb_regwrite}, {31'd0, sb_e[4]});
                chk("sb_wb_memtoreg", {31'd0, o_wb_memtoreg}, {31'd0, sb_e[3]});
                chk("sb_wb_wr_reg", {29'd0, o_wb_wr_reg}, {29'd0, sb_e[2:0]});
            end
        end
    end

    initial begin
        rst = 1'b1;
        i_flush = 1'b0;
        i_stall_ext = 1'b1;
        drv(1'b1, OP_BAD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);

        // reset state, with stall and an illegal opcode presented
        nxt();
        chk("rst_ex_valid", o_ex_valid, 0);
        chk("rst_mem_valid", o_mem_valid, 0);
        chk("rst_wb_valid", o_wb_valid, 0);
        chk("rst_halted", o_halted, 0);
        chk("rst_err", o_err, 0);
        chk("rst_hazard_stall", o_hazard_stall, 0);
        i_stall_ext = 1'b0;
        idle();
        rst = 1'b0;
        nxt();

        // addi / xori / st decode and latency
        drv(1'b1, OP_ADDI, 3'd1, 1'b1, 3'd0, 1'b0, 3'd3); push(1, 0, 3'd3);
        nxt();
        idle();
        chk("addi_ex_valid", o_ex_valid, 1);
        chk("addi_ex_alusrc", o_ex_alusrc, 1);
        chk("addi_ex_i1fmt", o_ex_i1fmt, 1);
        chk("addi_ex_aluop", o_ex_aluop, 32'd8);
        chk("addi_ex_branch", o_ex_branch, 0);
        chk("addi_mem_valid_early", o_mem_valid, 0);
        nxt();
        chk("addi_mem_valid", o_mem_valid, 1);
        chk("addi_mem_write", o_mem_write, 0);
        drv(1'b1, OP_XORI, 3'd1, 1'b1, 3'd0, 1'b0, 3'd4); push(1, 0, 3'd4);
        nxt();
        chk("addi_wb_valid", o_wb_valid, 1);
        chk("addi_wb_regwrite", o_wb_regwrite, 1);
        chk("addi_wb_wr_reg", o_wb_wr_reg, 32'd3);
        chk("xori_ex_zeroext", o_ex_zeroext, 1);
        drv(1'b1, OP_ST, 3'd1, 1'b1, 3'd2, 1'b1, 3'd0); push(0, 0, 3'd0);
        nxt();
        idle();
        nxt();
        chk("st_mem_write", o_mem_write, 1);
        nxt();

        // load-use on rs
        drv(1'b1, OP_LD, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2); push(1, 1, 3'd2);
        nxt();
        drv(1'b1, OP_ADD, 3'd2, 1'b1, 3'd3, 1'b1, 3'd4);
        #1 chk("lu_rs_stall", o_hazard_stall, 1);
        nxt();
        #1 chk("lu_rs_stall_once", o_hazard_stall, 0);
        chk("lu_bubble_ex", o_ex_valid, 0);
        chk("lu_ld_mem_read", o_mem_read, 1);
        push(1, 0, 3'd4);
        nxt();
        chk("lu_add_ex_valid", o_ex_valid, 1);
        chk("lu_add_ex_aluop", o_ex_aluop, 32'd27);
        chk("lu_add_ex_alusrc", o_ex_alusrc, 0);
        drv(1'b1, OP_LD, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2); push(1, 1, 3'd2);
        nxt();
        drv(1'b1, OP_ADD, 3'd2, 1'b0, 3'd5, 1'b1, 3'd6);
        #1 chk("lu_rs_unused_nostall", o_hazard_stall, 0);
        push(1, 0, 3'd6);
        nxt();
        // load to r0 followed by an rt reader of r0
        drv(1'b1, OP_LD, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0); push(1, 1, 3'd0);
        nxt();
        drv(1'b1, OP_ADD, 3'd4, 1'b1, 3'd0, 1'b1, 3'd7);
        #1 chk("lu_rt_r0_stall", o_hazard_stall, 1);
        nxt();
        #1 chk("lu_rt_r0_release", o_hazard_stall, 0);
        push(1, 0, 3'd7);
        nxt();
        idle();
        nxt();

        // flush overrides load-use
        drv(1'b1, OP_LD, 3'd1, 1'b1, 3'd0, 1'b0, 3'd1); push(1, 1, 3'd1);
        nxt();
        drv(1'b1, OP_ADD, 3'd1, 1'b1, 3'd0, 1'b0, 3'd5);
        i_flush = 1'b1;
        #1 chk("flush_lu_stall", o_hazard_stall, 0);
        nxt();
        i_flush = 1'b0;
        idle();
        chk("flush_bubble_ex", o_ex_valid, 0);
        chk("flush_ld_mem_read", o_mem_read, 1);
        nxt();
        // stall_ext overrides flush and load-use
        drv(1'b1, OP_LD, 3'd1, 1'b1, 3'd0, 1'b0, 3'd1); push(1, 1, 3'd1);
        nxt();
        drv(1'b1, OP_ADD, 3'd1, 1'b1, 3'd0, 1'b0, 3'd5);
        i_flush = 1'b1;
        i_stall_ext = 1'b1;
        #1 chk("stallext_stall", o_hazard_stall, 1);
        nxt();
        i_flush = 1'b0;
        i_stall_ext = 1'b0;
        idle();
        chk("stallext_ex_held", o_ex_valid, 1);
        chk("stallext_ex_aluop", o_ex_aluop, 32'd17);
        nxt();
        chk("stallext_then_bubble", o_ex_valid, 0);
        chk("stallext_ld_mem_read", o_mem_read, 1);
        nxt(); nxt(); nxt();

        // reset mid-stream with three valid entries
        drv(1'b1, OP_ADD, 3'd1, 1'b1, 3'd2, 1'b1, 3'd1); push(1, 0, 3'd1);
        nxt();
        drv(1'b1, OP_ADD, 3'd1, 1'b1, 3'd2, 1'b1, 3'd2); push(1, 0, 3'd2);
        nxt();
        drv(1'b1, OP_ADD, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3); push(1, 0, 3'd3);
        nxt();
        idle();
        chk("pre_rst_ex_valid", o_ex_valid, 1);
        chk("pre_rst_mem_valid", o_mem_valid, 1);
        chk("pre_rst_wb_valid", o_wb_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ex_valid", o_ex_valid, 0);
        chk("mid_rst_ex_aluop", o_ex_aluop, 0);
        chk("mid_rst_mem_valid", o_mem_valid, 0);
        chk("mid_rst_wb_valid", o_wb_valid, 0);
        chk("mid_rst_wb_regwrite", o_wb_regwrite, 0);
        chk("mid_rst_halted", o_halted, 0);
        sb_q.delete();
        nxt();
        rst = 1'b0;
        nxt();

        // halt followed by adds
        drv(1'b1, OP_HALT, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0); push(0, 0, 3'd0);
        nxt();
        drv(1'b1, OP_ADD, 3'd1, 1'b1, 3'd2, 1'b1, 3'd5); push(1, 0, 3'd5);
        nxt();
        drv(1'b1, OP_ADD, 3'd1, 1'b1, 3'd2, 1'b1, 3'd6); push(1, 0, 3'd6);
        chk("halt_not_yet", o_halted, 0);
        nxt();
        drv(1'b1, OP_ADD, 3'd1, 1'b1, 3'd2, 1'b1, 3'd7);
        chk("halt_at_c3", o_halted, 1);
        chk("halt_wb_valid", o_wb_valid, 1);
        chk("halt_wb_regwrite", o_wb_regwrite, 0);
        nxt();
        chk("halt_ex_bubble_1", o_ex_valid, 0);
        chk("halt_sticky_1", o_halted, 1);
        nxt();
        chk("halt_ex_bubble_2", o_ex_valid, 0);
        chk("halt_sticky_2", o_halted, 1);
        idle();
        nxt(); nxt();
        #2 rst = 1'b1;
        #1 chk("halt_cleared_by_rst", o_halted, 0);
        nxt();
        rst = 1'b0;
        nxt();

        // illegal opcode (upper opcode bit set)
        drv(1'b1, OP_BAD, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3); push(0, 0, 3'd0);
        #1 chk("illegal_err", o_err, 1);
        nxt();
        idle();
`ifdef CTRL_ILLEGAL_TRAP_EN
        #1 chk("illegal_err_sticky", o_err, 1);
`else
        #1 chk("illegal_err_pulse", o_err, 0);
`endif
        chk("illegal_ex_valid", o_ex_valid, 1);
        chk("illegal_ex_aluop", o_ex_aluop, 0);
        chk("illegal_ex_alusrc", o_ex_alusrc, 0);
        nxt();
        nxt();
        chk("illegal_wb_valid", o_wb_valid, 1);
        chk("illegal_wb_regwrite", o_wb_regwrite, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("illegal_halted", o_halted, 1);
        chk("illegal_err_still", o_err, 1);
`else
        chk("illegal_not_halted", o_halted, 0);
        chk("illegal_err_gone", o_err, 0);
`endif
        nxt(); nxt(); nxt();

        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
